fifo_demux_1to2: RTL and testbench



---
 rtl/fifo_demux_1to2_if.sv | 29 ++
 rtl/fifo_demux_1to2.sv | 95 +++++++++
 tb/tb_fifo_demux_1to2.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_demux_1to2_if.sv
// Handshake bundle for fifo_demux_1to2: one input stream and two drained lanes.
// The master modport is the producer/consumer side and the slave modport is the distributor.
interface fifo_demux_1to2_if #(
  parameter int WIDTH = 2,
  parameter int AW    = 2
);
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [AW:0]      count0;
  logic [AW:0]      count1;

  modport master (
    output in_data, in_sel, in_valid, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid, count0, count1
  );

  modport slave (
    input  in_data, in_sel, in_valid, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out1_data, out1_valid, count0, count1
  );
endinterface

// File: rtl/fifo_demux_1to2.sv
// Write-side distributor: steers each input word into one of two first-word-fall-through lane FIFOs.
// Define FIFO_DEMUX_ROUND_ROBIN_EN to alternate lanes on accepted pushes instead of using in_sel.
module fifo_demux_1to2 #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic              clk,
  input logic              rst,
  fifo_demux_1to2_if.slave bus
);

  logic [WIDTH-1:0] mem_q    [2][DEPTH];
  logic [AW:0]      wr_ptr_q [2];
  logic [AW:0]      rd_ptr_q [2];

  logic [1:0] empty;
  logic [1:0] full;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] out_ready;
  logic       tgt;
  logic       accept;

  assign out_ready = {bus.out1_ready, bus.out0_ready};

  always_comb begin
    for (int l = 0; l < 2; l++) begin
      empty[l] = (wr_ptr_q[l] == rd_ptr_q[l]);
      full[l]  = (wr_ptr_q[l][AW-1:0] == rd_ptr_q[l][AW-1:0]) &&
                 (wr_ptr_q[l][AW] != rd_ptr_q[l][AW]);
    end
  end

`ifdef FIFO_DEMUX_ROUND_ROBIN_EN
  logic rr_q;
  logic unused_sel;

  assign unused_sel = bus.in_sel;
  assign tgt        = rr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else if (accept) begin
      rr_q <= ~rr_q;
    end
  end
`else
  // in_sel=1 selects lane 0, matching the read-side 2:1 select polarity.
  assign tgt = ~bus.in_sel;
`endif

  assign bus.in_ready = ~full[tgt];
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    for (int l = 0; l < 2; l++) begin
      push[l] = accept && (tgt == 1'(l));
      pop[l]  = !empty[l] && out_ready[l];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: storage is reset as well, so a freshly reset lane never exposes stale words.
      for (int l = 0; l < 2; l++) begin
        wr_ptr_q[l] <= '0;
        rd_ptr_q[l] <= '0;
        for (int e = 0; e < DEPTH; e++) begin
          mem_q[l][e] <= '0;
        end
      end
    end else begin
      for (int l = 0; l < 2; l++) begin
        if (push[l]) begin
          mem_q[l][wr_ptr_q[l][AW-1:0]] <= bus.in_data;
          wr_ptr_q[l]                   <= wr_ptr_q[l] + 1'b1;
        end
        if (pop[l]) begin
          rd_ptr_q[l] <= rd_ptr_q[l] + 1'b1;
        end
      end
    end
  end

  assign bus.out0_valid = ~empty[0];
  assign bus.out1_valid = ~empty[1];
  assign bus.out0_data  = empty[0] ? '0 : mem_q[0][rd_ptr_q[0][AW-1:0]];
  assign bus.out1_data  = empty[1] ? '0 : mem_q[1][rd_ptr_q[1][AW-1:0]];
  assign bus.count0     = wr_ptr_q[0] - rd_ptr_q[0];
  assign bus.count1     = wr_ptr_q[1] - rd_ptr_q[1];

endmodule

// File: tb/tb_fifo_demux_1to2.sv
// Self-checking bench for fifo_demux_1to2: directed steps plus a short random run, scored
// against per-lane expected-word queues. Honors FIFO_DEMUX_ROUND_ROBIN_EN when defined.
module tb_fifo_demux_1to2;
  localparam int WIDTH = 2;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk;
  logic rst;

  fifo_demux_1to2_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  fifo_demux_1to2 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic             rr_m;
  int               n_vec;
  int               n_miss;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    check("count0", 32'(bus.count0), 32'(q0.size()));
    check("count1", 32'(bus.count1), 32'(q1.size()));
    check("out0_valid", 32'(bus.out0_valid), 32'(q0.size() != 0));
    check("out1_valid", 32'(bus.out1_valid), 32'(q1.size() != 0));
    check("out0_data", 32'(bus.out0_data), (q0.size() != 0) ? 32'(q0[0]) : 32'd0);
    check("out1_data", 32'(bus.out1_data), (q1.size() != 0) ? 32'(q1[0]) : 32'd0);
  endtask

  // Called one time unit after a rising edge; returns one time unit after the next one.
  task automatic drive_cycle(input logic v, input logic sel, input logic [WIDTH-1:0] d,
                             input logic r0, input logic r1);
    logic lane;
    logic exp_rdy;
    bus.in_valid   = v;
    bus.in_sel     = sel;
    bus.in_data    = d;
    bus.out0_ready = r0;
    bus.out1_ready = r1;
    #1;
`ifdef FIFO_DEMUX_ROUND_ROBIN_EN
    lane = rr_m;
`else
    lane = ~sel;
`endif
    exp_rdy = lane ? (q1.size() != DEPTH) : (q0.size() != DEPTH);
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    if (r0 && q0.size() != 0) void'(q0.pop_front());
    if (r1 && q1.size() != 0) void'(q1.pop_front());
    if (v && exp_rdy) begin
      if (lane) q1.push_back(d);
      else      q0.push_back(d);
      rr_m = ~rr_m;
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive_cycle(1'b0, 1'b1, '0, 1'b1, 1'b1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rr_m   = 1'b0;
    rst    = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_sel     = 1'b1;
    bus.in_data    = '0;
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_state();

    // Reset mid-operation: three words into lane 0, then an async reset between edges.
    drive_cycle(1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b1, 2'd3, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    q0.delete();
    q1.delete();
    rr_m = 1'b0;
    check("rst_out0_valid", 32'(bus.out0_valid), 32'd0);
    check("rst_count0", 32'(bus.count0), 32'd0);
    check("rst_out0_data", 32'(bus.out0_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_sel = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    check_state();

    // Steering by in_sel, visible on the push edge.
    drive_cycle(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    drain();

    // Full boundary on lane 0, other lane still open, fifth push refused.
    for (int i = 0; i < DEPTH; i++) begin
      drive_cycle(1'b1, 1'b1, WIDTH'(i), 1'b0, 1'b0);
    end
    bus.in_valid = 1'b0;
    bus.in_sel   = 1'b0;
    #1;
`ifndef FIFO_DEMUX_ROUND_ROBIN_EN
    check("lane1_open_ready", 32'(bus.in_ready), 32'd1);
`endif
    @(posedge clk);
    #1;
    drive_cycle(1'b1, 1'b1, 2'd3, 1'b0, 1'b0);

    // Full lane with pop and push in the same cycle: pop only, push lands next cycle.
    drive_cycle(1'b1, 1'b1, 2'd2, 1'b1, 1'b0);
    drive_cycle(1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
    drain();

    // Stream through lane 1 across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b1, 1'b0, WIDTH'(i % 4), 1'b0, 1'b1);
      check("lane1_le1", 32'(bus.count1 <= 1), 32'd1);
    end
    drain();

`ifdef FIFO_DEMUX_ROUND_ROBIN_EN
    // Round-robin: constant in_sel, lanes alternate; full lane stalls on its turn.
    drive_cycle(1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b1, 2'd3, 1'b0, 1'b0);
    check("rr_lane0_head", 32'(bus.out0_data), 32'd0);
    check("rr_lane1_head", 32'(bus.out1_data), 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, 1'b1, WIDTH'(i), 1'b0, 1'b0);
    end
    drive_cycle(1'b0, 1'b1, 2'd0, 1'b1, 1'b0);
    drive_cycle(1'b1, 1'b1, 2'd3, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b1, 2'd3, 1'b0, 1'b0);
    drain();
`endif

    // Short random run against the scoreboard.
    for (int i = 0; i < 60; i++) begin
      drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), WIDTH'($urandom),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
